// File: rtl/pinky_hazard_ctrl.sv
// PinKY 4-stage pipeline interlock: RAW/Z scoreboard, stall/bubble generation,
// PC-write flush and drain-then-halt sequencing on SYS.
module pinky_hazard_ctrl #(
  parameter bit BYPASS_WB  = 1'b0,
  parameter bit HALT_DRAIN = 1'b1,
  localparam int unsigned IR_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IR_W-1:0] ir,
  input  logic            ir_valid,
  output logic            stall,
  output logic            bubble,
  output logic            flush,
  output logic            halt,
  output logic            sb_busy
);

  localparam int unsigned OP_W  = 5;
  localparam int unsigned CC_W  = 2;
  localparam int unsigned REG_W = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 5'd0;
  localparam logic [OP_W-1:0] OP_ADDF = 5'd1;
  localparam logic [OP_W-1:0] OP_AND  = 5'd2;
  localparam logic [OP_W-1:0] OP_BIC  = 5'd3;
  localparam logic [OP_W-1:0] OP_EOR  = 5'd4;
  localparam logic [OP_W-1:0] OP_FTOI = 5'd5;
  localparam logic [OP_W-1:0] OP_ITOF = 5'd6;
  localparam logic [OP_W-1:0] OP_LDR  = 5'd7;
  localparam logic [OP_W-1:0] OP_MOV  = 5'd8;
  localparam logic [OP_W-1:0] OP_MUL  = 5'd9;
  localparam logic [OP_W-1:0] OP_MULF = 5'd10;
  localparam logic [OP_W-1:0] OP_NEG  = 5'd11;
  localparam logic [OP_W-1:0] OP_ORR  = 5'd12;
  localparam logic [OP_W-1:0] OP_RECF = 5'd13;
  localparam logic [OP_W-1:0] OP_SHA  = 5'd14;
  localparam logic [OP_W-1:0] OP_SLT  = 5'd15;
  localparam logic [OP_W-1:0] OP_SUB  = 5'd16;
  localparam logic [OP_W-1:0] OP_SUBF = 5'd17;
  localparam logic [OP_W-1:0] OP_STR  = 5'd18;
  localparam logic [OP_W-1:0] OP_SYS  = 5'd19;
  localparam logic [OP_W-1:0] OP_NOP  = 5'd20;
  localparam logic [OP_W-1:0] OP_PRE  = 5'd21;

  localparam logic [CC_W-1:0]  CC_S   = 2'd1;
  localparam logic [CC_W-1:0]  CC_NE  = 2'd2;
  localparam logic [CC_W-1:0]  CC_EQ  = 2'd3;
  localparam logic [REG_W-1:0] REG_PC = 4'd15;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             sets_z;
  } sb_entry_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t           state, state_nxt;
  sb_entry_t        sb1, sb2, sb3, sb1_nxt;
  logic [OP_W-1:0]  op;
  logic [CC_W-1:0]  cc;
  logic             imm;
  logic [REG_W-1:0] rd, rn;
  logic             is_writer, rd_src, rn_src, z_dep, is_sys, is_pre;
  logic             hazard, accept, flush_det;

  assign op  = ir[15:11];
  assign cc  = ir[10:9];
  assign imm = ir[8];
  assign rd  = ir[7:4];
  assign rn  = ir[3:0];

  // Classify the stage0 instruction: does it write Rd, and which fields it reads.
  always_comb begin
    is_writer = 1'b0;
    rd_src    = 1'b0;
    rn_src    = !imm;
    is_sys    = 1'b0;
    is_pre    = 1'b0;
    case (op)
      OP_ADD, OP_ADDF, OP_AND, OP_BIC, OP_EOR, OP_MUL, OP_MULF,
      OP_ORR, OP_SHA, OP_SLT, OP_SUB, OP_SUBF: begin
        is_writer = 1'b1;
        rd_src    = 1'b1;
      end
      OP_MOV, OP_NEG, OP_LDR, OP_FTOI, OP_ITOF, OP_RECF: is_writer = 1'b1;
      OP_STR: rd_src = 1'b1;
      OP_SYS: begin
        is_sys = 1'b1;
        rn_src = 1'b0;
      end
      OP_NOP: rn_src = 1'b0;
      OP_PRE: begin
        is_pre = 1'b1;
        rn_src = 1'b0;
      end
      default: ;
    endcase
  end

  assign z_dep = (cc == CC_NE) || (cc == CC_EQ);

  function automatic logic entry_hit(input sb_entry_t e,
                                     input logic [REG_W-1:0] src_a, input logic use_a,
                                     input logic [REG_W-1:0] src_b, input logic use_b,
                                     input logic use_z);
    return (e.valid && ((use_a && (e.dest == src_a)) || (use_b && (e.dest == src_b))))
           || (use_z && e.sets_z);
  endfunction

  // A write-through regfile makes the stage3 writer visible to stage1 already.
  assign hazard = !is_pre &&
                  (entry_hit(sb1, rd, rd_src, rn, rn_src, z_dep) ||
                   entry_hit(sb2, rd, rd_src, rn, rn_src, z_dep) ||
                   (!BYPASS_WB && entry_hit(sb3, rd, rd_src, rn, rn_src, z_dep)));

  assign flush_det = sb3.valid && (sb3.dest == REG_PC);
  assign sb_busy   = sb1.valid || sb2.valid || sb3.valid;
  assign bubble    = stall;

  // Sequencer: issue control in RUN, hold stage0 while draining or halted.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_RUN: begin
        if (!flush) begin
          stall  = ir_valid && hazard;
          accept = !stall;
          if (accept && ir_valid && is_sys && !flush_det)
            state_nxt = HALT_DRAIN ? ST_DRAIN : ST_HALTED;
        end
      end
      ST_DRAIN: begin
        stall = !flush;
        if (flush)         state_nxt = ST_RUN;
        else if (!sb_busy) state_nxt = ST_HALTED;
      end
      ST_HALTED: stall = 1'b1;
      default:   state_nxt = ST_RUN;
    endcase
  end

  // Entry shifted into SB1; empty unless a real instruction issues.
  always_comb begin
    sb1_nxt = '0;
    if (accept && ir_valid) begin
      sb1_nxt.valid  = is_writer;
      sb1_nxt.dest   = rd;
      sb1_nxt.sets_z = (cc == CC_S);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
      sb1   <= '0;
      sb2   <= '0;
      sb3   <= '0;
      flush <= 1'b0;
      halt  <= 1'b0;
    end else begin
      state <= state_nxt;
      flush <= flush_det;
      halt  <= (state_nxt == ST_HALTED);
      if (flush_det) begin
        sb1 <= '0;
        sb2 <= '0;
        sb3 <= '0;
      end else begin
        sb1 <= sb1_nxt;
        sb2 <= sb1;
        sb3 <= sb2;
      end
    end
  end

endmodule

// File: tb/tb_pinky_hazard_ctrl.sv
// Vector-table bench for pinky_hazard_ctrl across BYPASS_WB / HALT_DRAIN variants.
module tb_pinky_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ir_valid;
  logic [15:0] ir;
  logic [2:0]  stall_v, bubble_v, flush_v, halt_v, busy_v;

  always #5 clk = ~clk;

  // 0: BYPASS_WB=0 HALT_DRAIN=1, 1: BYPASS_WB=1 HALT_DRAIN=1, 2: BYPASS_WB=0 HALT_DRAIN=0
  pinky_hazard_ctrl #(.BYPASS_WB(1'b0), .HALT_DRAIN(1'b1)) u_dut (
    .clk(clk), .reset(reset), .ir(ir), .ir_valid(ir_valid),
    .stall(stall_v[0]), .bubble(bubble_v[0]), .flush(flush_v[0]),
    .halt(halt_v[0]), .sb_busy(busy_v[0]));

  pinky_hazard_ctrl #(.BYPASS_WB(1'b1), .HALT_DRAIN(1'b1)) u_byp (
    .clk(clk), .reset(reset), .ir(ir), .ir_valid(ir_valid),
    .stall(stall_v[1]), .bubble(bubble_v[1]), .flush(flush_v[1]),
    .halt(halt_v[1]), .sb_busy(busy_v[1]));

  pinky_hazard_ctrl #(.BYPASS_WB(1'b0), .HALT_DRAIN(1'b0)) u_nodrain (
    .clk(clk), .reset(reset), .ir(ir), .ir_valid(ir_valid),
    .stall(stall_v[2]), .bubble(bubble_v[2]), .flush(flush_v[2]),
    .halt(halt_v[2]), .sb_busy(busy_v[2]));

  typedef struct {
    logic        rst;
    logic        v;
    logic [15:0] ir;
    logic [1:0]  sel;
    logic        chk;
    logic        s, f, h, b;
  } vec_t;

  typedef struct {
    logic [1:0] sel;
    logic       s, f, h, b;
    int         idx;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   vec_no   = 0;

  task automatic cmp(input string name, input int idx, input logic [1:0] sel,
                     input logic act, input logic want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s vec=%0d dut=%0d got=%b want=%b", name, idx, sel, act, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp("stall",   e.idx, e.sel, stall_v[e.sel],  e.s);
      cmp("bubble",  e.idx, e.sel, bubble_v[e.sel], e.s);
      cmp("flush",   e.idx, e.sel, flush_v[e.sel],  e.f);
      cmp("halt",    e.idx, e.sel, halt_v[e.sel],   e.h);
      cmp("sb_busy", e.idx, e.sel, busy_v[e.sel],   e.b);
    end
  end

  task automatic add(input logic rst, input logic v, input logic [15:0] i,
                     input logic [1:0] sel, input logic chk, input logic [3:0] sfhb);
    vec_t x;
    x.rst = rst; x.v = v; x.ir = i; x.sel = sel; x.chk = chk;
    x.s = sfhb[3]; x.f = sfhb[2]; x.h = sfhb[1]; x.b = sfhb[0];
    vecs.push_back(x);
  endtask

  task automatic rs(input logic [1:0] sel);
    add(1'b1, 1'b0, 16'hA000, sel, 1'b0, 4'b0000);
  endtask

  task automatic ck(input logic [15:0] i, input logic [1:0] sel, input logic [3:0] sfhb);
    add(1'b0, 1'b1, i, sel, 1'b1, sfhb);
  endtask

  task automatic id(input logic [1:0] sel, input logic [3:0] sfhb);
    add(1'b0, 1'b0, 16'hA000, sel, 1'b1, sfhb);
  endtask

  // One cycle: drive just after the edge, expectation checked on the falling edge.
  task automatic drive(input vec_t x);
    exp_t e;
    @(posedge clk);
    #1;
    reset    = x.rst;
    ir_valid = x.v;
    ir       = x.ir;
    if (x.chk) begin
      e.sel = x.sel; e.s = x.s; e.f = x.f; e.h = x.h; e.b = x.b; e.idx = vec_no;
      exp_q.push_back(e);
    end
    vec_no++;
  endtask

  task automatic step(input logic rst, input logic v, input logic [15:0] i,
                      input logic [1:0] sel, input logic chk, input logic [3:0] sfhb);
    vec_t x;
    x.rst = rst; x.v = v; x.ir = i; x.sel = sel; x.chk = chk;
    x.s = sfhb[3]; x.f = sfhb[2]; x.h = sfhb[1]; x.b = sfhb[0];
    drive(x);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    ir_valid = 1'b0;
    ir       = 16'hA000;

    // expected nibble = {stall, flush, halt, sb_busy}; bubble must equal stall
    // RAW on r1, three stall cycles without write-through
    rs(0); ck(16'h0012,0,4'b0000); ck(16'h0031,0,4'b1001); ck(16'h0031,0,4'b1001);
    ck(16'h0031,0,4'b1001); ck(16'h0031,0,4'b0000); id(0,4'b0001);
    // same with write-through: two stall cycles
    rs(1); ck(16'h0012,1,4'b0000); ck(16'h0031,1,4'b1001); ck(16'h0031,1,4'b1001);
    ck(16'h0031,1,4'b0001); id(1,4'b0001);
    // independent stream
    rs(0); ck(16'h0012,0,4'b0000); ck(16'h0034,0,4'b0001); ck(16'h0056,0,4'b0001);
    ck(16'h4171,0,4'b0001); id(0,4'b0001);
    // Z dependence only
    rs(0); ck(16'h0311,0,4'b0000); ck(16'h0622,0,4'b1001); ck(16'h0622,0,4'b1001);
    ck(16'h0622,0,4'b1001); ck(16'h0622,0,4'b0000); id(0,4'b0001);
    // PC write -> flush 3 cycles after accept, scoreboard emptied
    rs(0); ck(16'h41F4,0,4'b0000); ck(16'h0012,0,4'b0001); ck(16'h0034,0,4'b0001);
    ck(16'h0056,0,4'b0001); ck(16'h0056,0,4'b0100); id(0,4'b0000);
    // SYS with drain
    rs(0); ck(16'h0012,0,4'b0000); ck(16'h9800,0,4'b0001); id(0,4'b1001);
    id(0,4'b1001); id(0,4'b1000); id(0,4'b1010); id(0,4'b1010);
    // SYS without drain
    rs(2); ck(16'h0012,2,4'b0000); ck(16'h9800,2,4'b0001); id(2,4'b1011);
    id(2,4'b1011); id(2,4'b1010);
    // reset in the second stall cycle
    rs(0); ck(16'h0012,0,4'b0000); ck(16'h0031,0,4'b1001);
    add(1'b1, 1'b1, 16'h0031, 2'd0, 1'b0, 4'b0000);
    ck(16'h0031,0,4'b0000); id(0,4'b0001);
    // SYS.EQ waits on Z hazard before draining
    rs(0); ck(16'h0311,0,4'b0000); ck(16'h9E00,0,4'b1001); ck(16'h9E00,0,4'b1001);
    ck(16'h9E00,0,4'b1001); ck(16'h9E00,0,4'b0000); id(0,4'b1000); id(0,4'b1010);
    // PRE never stalls; following instruction still does
    rs(0); ck(16'h0012,0,4'b0000); ck(16'hAE01,0,4'b0001); ck(16'h0031,0,4'b1001);
    ck(16'h0031,0,4'b1001); ck(16'h0031,0,4'b0000); id(0,4'b0001);
    // flush during DRAIN returns to RUN
    rs(0); ck(16'h41F4,0,4'b0000); ck(16'h9800,0,4'b0001); id(0,4'b1001);
    id(0,4'b1001); id(0,4'b0100); ck(16'h0012,0,4'b0000); id(0,4'b0001);

    foreach (vecs[k]) drive(vecs[k]);

    // reset in the middle of a drain
    step(1'b1, 1'b0, 16'hA000, 2'd0, 1'b0, 4'b0000);
    step(1'b0, 1'b1, 16'h0012, 2'd0, 1'b1, 4'b0000);
    step(1'b0, 1'b1, 16'h9800, 2'd0, 1'b1, 4'b0001);
    step(1'b0, 1'b0, 16'hA000, 2'd0, 1'b1, 4'b1001);
    step(1'b1, 1'b0, 16'hA000, 2'd0, 1'b0, 4'b0000);
    step(1'b0, 1'b1, 16'h0031, 2'd0, 1'b1, 4'b0000);
    step(1'b0, 1'b0, 16'hA000, 2'd0, 1'b1, 4'b0001);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_queue got=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
